fitness_session_ctrl: RTL and testbench
=======================================

Name: fitness_session_ctrl

Overview:
- Session controller for the step-tracker datapath.
- Sequences the session through idle, run and pause, and gates step pulses into the step register.
- Derives distance in tenths of a mile from the step count, times the active session, and tracks the previous second's step rate.
- Rotates a 4-way display selector that feeds the seven-segment driver.

Parameters:
TICKS_PER_SEC, 100000000, clk cycles per second (the bench uses 10).
DISPLAY_SECS, 2, seconds each display mode is held before rotating.
STEP_MAX, 9999, saturation ceiling for step count and run seconds (4-digit display).

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low; clears all state.
start  input  1  synchronous single-cycle request: begin or resume a session.
stop  input  1  synchronous single-cycle request: pause the session.
clear  input  1  synchronous single-cycle request: end the session and zero all counters.
step_pulse  input  1  single-cycle step strobe, already synchronised and debounced.
stepcount  output  16  session step count, binary.
distance  output  16  tenths of a mile: floor(stepcount/2048)*5.
run_secs  output  16  seconds spent in RUN.
step_rate  output  16  steps counted in the last completed RUN second.
mode  output  2  display select: 0 steps, 1 distance, 2 run_secs, 3 step_rate.
display_value  output  16  value of the currently selected field.
running  output  1  high in RUN.
saturated  output  1  high while stepcount == STEP_MAX.

Behaviour:
- Reset (reset low, asynchronous):
  - State = IDLE; all counters, prescalers and outputs = 0; mode = 0.
  - Deassertion is synchronous to clk.
- FSM states: IDLE, RUN, PAUSE. Request priority per cycle is clear > stop > start.
  - IDLE: start goes to RUN. stop is ignored.
  - RUN: stop goes to PAUSE. clear goes to IDLE.
  - PAUSE: start goes to RUN. clear goes to IDLE.
  - clear in IDLE: no state change; counters remain 0.
  - start in RUN and stop in PAUSE are ignored (no-ops).
- Entering IDLE via clear:
  - Zeroes stepcount, distance, run_secs, step_rate, both prescalers, the second accumulator and mode.
  - Takes effect on the same edge as the state change.
- Step counting:
  - A step_pulse sampled in RUN increments stepcount on that edge.
  - Pulses in IDLE or PAUSE are dropped.
  - stepcount saturates at STEP_MAX; saturated is asserted combinationally from stepcount.
  - A pulse coincident with stop in RUN is counted. A pulse coincident with clear is dropped.
- Distance:
  - Registered; updates one cycle after stepcount changes.
  - Computed as (stepcount >> 11) * 5, truncated to 16 bits.
  - Never cleared independently of stepcount.
- Second tick:
  - The prescaler counts only in RUN and freezes in PAUSE.
  - A tick occurs when the prescaler reaches TICKS_PER_SEC-1, after which it wraps to 0.
  - On a tick, run_secs increments (saturating at STEP_MAX).
  - On a tick, step_rate is loaded with the per-second accumulator, including any pulse counted on that same cycle, and the accumulator restarts at 0.
  - The accumulator saturates at STEP_MAX.
- Display rotation:
  - A separate prescaler plus seconds counter runs in RUN and PAUSE.
  - Every DISPLAY_SECS seconds, mode advances 0→1→2→3→0.
  - In IDLE, mode is held at 0 and the rotation timer is held at 0.
  - A stop or start transition does not reset the rotation timer.
- display_value: combinational mux of the four fields by mode; zero latency.
- running: registered state decode (high when state == RUN).

Test Plan:
1. Reset, then start, then 3 step_pulses, then stop: running 1→0, stepcount=3, distance=0, and 2 pulses sent while paused are not counted.
2. Start, then 2048 pulses: stepcount=2048, distance=5 one cycle later. Continuing to 4096 pulses gives distance=10.
3. With TICKS_PER_SEC=10, start and inject 4 pulses in the first 10 cycles: at cycle 10, run_secs=1 and step_rate=4. In the next second with 0 pulses, step_rate becomes 0.
4. DISPLAY_SECS=2, TICKS_PER_SEC=10, start held in RUN for 80 cycles: mode steps through 1, 2, 3, 0 at cycles 20, 40, 60, 80, and display_value tracks the selected field.
5. Start, preload to STEP_MAX-1 via pulses, then 3 more pulses: stepcount=9999 and saturated=1. Asserting clear, stop and start in the same cycle → IDLE, all counters 0, mode=0.
6. Drive reset low mid-RUN asynchronously, between clock edges: all outputs 0 immediately. Release reset, then start: counting resumes from 0.

Source files
------------

// File: rtl/fitness_session_ctrl.sv
// Step-tracker session controller: IDLE/RUN/PAUSE sequencing, step, distance,
// run-time and step-rate counters, plus a rotating display selector.
module fitness_session_ctrl #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int DISPLAY_SECS  = 2,
  parameter int STEP_MAX      = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        step_pulse,
  output logic [15:0] stepcount,
  output logic [15:0] distance,
  output logic [15:0] run_secs,
  output logic [15:0] step_rate,
  output logic [1:0]  mode,
  output logic [15:0] display_value,
  output logic        running,
  output logic        saturated,
  output logic [1:0]  state_dbg
);

  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int DW = (DISPLAY_SECS > 1) ? $clog2(DISPLAY_SECS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
  localparam logic [DW-1:0] DISP_LAST = DW'(DISPLAY_SECS - 1);
  localparam logic [15:0]   SMAX      = 16'(STEP_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          running_q, running_d;
  logic [15:0]   stepcount_q, stepcount_d;
  logic [15:0]   distance_q, distance_d;
  logic [15:0]   run_secs_q, run_secs_d;
  logic [15:0]   step_rate_q, step_rate_d;
  logic [15:0]   acc_q, acc_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [TW-1:0] disp_cnt_q, disp_cnt_d;
  logic [DW-1:0] disp_secs_q, disp_secs_d;
  logic [1:0]    mode_q, mode_d;

  logic          in_run;
  logic          step_take;
  logic          sec_tick;
  logic          disp_tick;
  logic [15:0]   acc_plus;

  // Requests are strictly prioritised: a stop present masks any start.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else if (stop) begin
      if (state_q == S_RUN) state_d = S_PAUSE;
    end else if (start) begin
      if (state_q != S_RUN) state_d = S_RUN;
    end
  end

  assign in_run    = (state_q == S_RUN);
  assign step_take = in_run && step_pulse && !clear;
  assign sec_tick  = in_run && (tick_cnt_q == TICK_LAST);
  assign disp_tick = (state_q != S_IDLE) && (disp_cnt_q == TICK_LAST);
  assign acc_plus  = (step_take && (acc_q < SMAX)) ? acc_q + 16'd1 : acc_q;

  always_comb begin
    running_d   = (state_d == S_RUN);
    stepcount_d = stepcount_q;
    distance_d  = 16'({11'd0, stepcount_q[15:11]} * 16'd5);
    run_secs_d  = run_secs_q;
    step_rate_d = step_rate_q;
    acc_d       = acc_plus;
    tick_cnt_d  = tick_cnt_q;
    disp_cnt_d  = disp_cnt_q;
    disp_secs_d = disp_secs_q;
    mode_d      = mode_q;

    if (step_take && (stepcount_q < SMAX)) stepcount_d = stepcount_q + 16'd1;

    if (in_run) begin
      if (sec_tick) begin
        tick_cnt_d  = '0;
        step_rate_d = acc_plus;
        acc_d       = 16'd0;
        if (run_secs_q < SMAX) run_secs_d = run_secs_q + 16'd1;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end

    // The rotation timer free-runs across RUN and PAUSE; only IDLE parks it.
    if (state_q == S_IDLE) begin
      disp_cnt_d  = '0;
      disp_secs_d = '0;
      mode_d      = 2'd0;
    end else if (disp_tick) begin
      disp_cnt_d = '0;
      if (disp_secs_q == DISP_LAST) begin
        disp_secs_d = '0;
        mode_d      = mode_q + 2'd1;
      end else begin
        disp_secs_d = disp_secs_q + 1'b1;
      end
    end else begin
      disp_cnt_d = disp_cnt_q + 1'b1;
    end

    if (clear) begin
      stepcount_d = 16'd0;
      distance_d  = 16'd0;
      run_secs_d  = 16'd0;
      step_rate_d = 16'd0;
      acc_d       = 16'd0;
      tick_cnt_d  = '0;
      disp_cnt_d  = '0;
      disp_secs_d = '0;
      mode_d      = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      running_q   <= 1'b0;
      stepcount_q <= 16'd0;
      distance_q  <= 16'd0;
      run_secs_q  <= 16'd0;
      step_rate_q <= 16'd0;
      acc_q       <= 16'd0;
      tick_cnt_q  <= '0;
      disp_cnt_q  <= '0;
      disp_secs_q <= '0;
      mode_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      running_q   <= running_d;
      stepcount_q <= stepcount_d;
      distance_q  <= distance_d;
      run_secs_q  <= run_secs_d;
      step_rate_q <= step_rate_d;
      acc_q       <= acc_d;
      tick_cnt_q  <= tick_cnt_d;
      disp_cnt_q  <= disp_cnt_d;
      disp_secs_q <= disp_secs_d;
      mode_q      <= mode_d;
    end
  end

  always_comb begin
    display_value = stepcount_q;
    case (mode_q)
      2'd0: display_value = stepcount_q;
      2'd1: display_value = distance_q;
      2'd2: display_value = run_secs_q;
      2'd3: display_value = step_rate_q;
      default: display_value = stepcount_q;
    endcase
  end

  assign stepcount = stepcount_q;
  assign distance  = distance_q;
  assign run_secs  = run_secs_q;
  assign step_rate = step_rate_q;
  assign mode      = mode_q;
  assign running   = running_q;
  assign saturated = (stepcount_q == SMAX);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fitness_session_ctrl.sv
// Bench for fitness_session_ctrl: cycle-level model checked every cycle, plus
// directed literal expectations for each scenario.
module tb_fitness_session_ctrl;

  localparam int TPS  = 10;
  localparam int DS   = 2;
  localparam int SMAX = 9999;

  logic        clk;
  logic        reset;
  logic        start, stop, clear, step_pulse;
  logic [15:0] stepcount, distance, run_secs, step_rate, display_value;
  logic [1:0]  mode, state_dbg;
  logic        running, saturated;

  int n_cmp = 0;
  int n_bad = 0;

  fitness_session_ctrl #(
    .TICKS_PER_SEC(TPS),
    .DISPLAY_SECS (DS),
    .STEP_MAX     (SMAX)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .clear        (clear),
    .step_pulse   (step_pulse),
    .stepcount    (stepcount),
    .distance     (distance),
    .run_secs     (run_secs),
    .step_rate    (step_rate),
    .mode         (mode),
    .display_value(display_value),
    .running      (running),
    .saturated    (saturated),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: 0 idle, 1 run, 2 pause; time kept as raw cycle counts since clear
  int m_state = 0, m_steps = 0, m_dist = 0, m_run_cyc = 0, m_live_cyc = 0;
  int m_sec_pulses = 0, m_rate = 0;
  bit m_counted;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = 0; m_steps = 0; m_dist = 0; m_run_cyc = 0; m_live_cyc = 0;
      m_sec_pulses = 0; m_rate = 0;
    end else if (clear) begin
      m_state = 0; m_steps = 0; m_dist = 0; m_run_cyc = 0; m_live_cyc = 0;
      m_sec_pulses = 0; m_rate = 0;
    end else begin
      m_counted = (m_state == 1) && step_pulse;
      m_dist = (m_steps / 2048) * 5;
      if (m_counted) begin
        if (m_steps < SMAX) m_steps = m_steps + 1;
        if (m_sec_pulses < SMAX) m_sec_pulses = m_sec_pulses + 1;
      end
      if (m_state == 1) begin
        m_run_cyc = m_run_cyc + 1;
        if (m_run_cyc % TPS == 0) begin
          m_rate = m_sec_pulses;
          m_sec_pulses = 0;
        end
      end
      if (m_state != 0) m_live_cyc = m_live_cyc + 1;
      if (stop) begin
        if (m_state == 1) m_state = 2;
      end else if (start) begin
        m_state = 1;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every cycle, outputs vs model
  always @(negedge clk) begin
    automatic int e_run  = (m_run_cyc / TPS > SMAX) ? SMAX : m_run_cyc / TPS;
    automatic int e_mode = (m_live_cyc / (TPS * DS)) % 4;
    automatic int e_disp = (e_mode == 0) ? m_steps : (e_mode == 1) ? m_dist :
                           (e_mode == 2) ? e_run : m_rate;
    check("m_stepcount", stepcount, 16'(m_steps));
    check("m_distance", distance, 16'(m_dist));
    check("m_run_secs", run_secs, 16'(e_run));
    check("m_step_rate", step_rate, 16'(m_rate));
    check("m_mode", {14'd0, mode}, 16'(e_mode));
    check("m_display", display_value, 16'(e_disp));
    check("m_running", {15'd0, running}, 16'(m_state == 1));
    check("m_saturated", {15'd0, saturated}, 16'(m_steps == SMAX));
  end

  // driver tasks
  task automatic cyc(input logic s, input logic p, input logic c, input logic sp);
    @(negedge clk);
    start = s; stop = p; clear = c; step_pulse = sp;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulses(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; step_pulse = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stepcount", stepcount, 16'd0);
    check("rst_mode", {14'd0, mode}, 16'd0);
    check("rst_running", {15'd0, running}, 16'd0);
    reset = 1'b1;

    // 1: start, 3 pulses, stop, pulses in pause dropped
    cyc(1, 0, 0, 0); idle(1);
    check("t1_running_on", {15'd0, running}, 16'd1);
    pulses(3); cyc(0, 1, 0, 0); idle(1);
    check("t1_running_off", {15'd0, running}, 16'd0);
    check("t1_steps", stepcount, 16'd3);
    check("t1_dist", distance, 16'd0);
    pulses(2); idle(1);
    check("t1_paused_steps", stepcount, 16'd3);

    // 2: distance thresholds
    cyc(0, 0, 1, 0); cyc(1, 0, 0, 0);
    pulses(2048); idle(1);
    check("t2_steps_2048", stepcount, 16'd2048);
    check("t2_dist_lag", distance, 16'd0);
    idle(1);
    check("t2_dist_5", distance, 16'd5);
    pulses(2048); idle(2);
    check("t2_steps_4096", stepcount, 16'd4096);
    check("t2_dist_10", distance, 16'd10);

    // 3: second tick and step rate
    cyc(0, 0, 1, 0); cyc(1, 0, 0, 0);
    pulses(4); idle(6);
    check("t3_secs_pre", run_secs, 16'd0);
    idle(1);
    check("t3_secs_1", run_secs, 16'd1);
    check("t3_rate_4", step_rate, 16'd4);
    idle(10);
    check("t3_secs_2", run_secs, 16'd2);
    check("t3_rate_0", step_rate, 16'd0);

    // 4: display rotation, pulse on odd cycles
    cyc(0, 0, 1, 0); cyc(1, 0, 0, 0);
    for (int k = 1; k <= 81; k++) begin
      cyc(0, 0, 0, (k <= 80) && (k % 2 == 1));
      if (k == 20) check("t4_mode_pre", {14'd0, mode}, 16'd0);
      if (k == 21) check("t4_mode_1", {14'd0, mode}, 16'd1);
      if (k == 41) begin
        check("t4_mode_2", {14'd0, mode}, 16'd2);
        check("t4_disp_secs", display_value, 16'd4);
      end
      if (k == 61) begin
        check("t4_mode_3", {14'd0, mode}, 16'd3);
        check("t4_disp_rate", display_value, 16'd5);
      end
      if (k == 81) begin
        check("t4_mode_0", {14'd0, mode}, 16'd0);
        check("t4_disp_steps", display_value, 16'd40);
      end
    end

    // 5: saturation, then clear+stop+start together
    cyc(0, 0, 1, 0); cyc(1, 0, 0, 0);
    pulses(SMAX - 1); idle(1);
    check("t5_steps_pre", stepcount, 16'd9998);
    check("t5_sat_pre", {15'd0, saturated}, 16'd0);
    pulses(3); idle(1);
    check("t5_steps_max", stepcount, 16'd9999);
    check("t5_sat", {15'd0, saturated}, 16'd1);
    cyc(1, 1, 1, 1); idle(1);
    check("t5_clr_steps", stepcount, 16'd0);
    check("t5_clr_running", {15'd0, running}, 16'd0);
    check("t5_clr_mode", {14'd0, mode}, 16'd0);
    check("t5_clr_secs", run_secs, 16'd0);
    check("t5_clr_dist", distance, 16'd0);

    // 6: asynchronous reset mid-run
    cyc(1, 0, 0, 0); pulses(5);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("t6_async_steps", stepcount, 16'd0);
    check("t6_async_running", {15'd0, running}, 16'd0);
    check("t6_async_secs", run_secs, 16'd0);
    check("t6_async_disp", display_value, 16'd0);
    @(negedge clk);
    reset = 1'b1; step_pulse = 1'b0;
    cyc(1, 0, 0, 0); pulses(2); idle(1);
    check("t6_resume_steps", stepcount, 16'd2);
    check("t6_resume_running", {15'd0, running}, 16'd1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
